// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a round-robin common data bus broadcaster
module cdb_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SRC_W-1:0]            cdb_src,
  output logic [15:0]                 drop_cnt
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int ENT_W = TAG_W + DATA_W;
  logic [ENT_W-1:0] mem [NUM_SRC][BUF_DEPTH];
  logic [CNT_W-1:0] count [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  logic [SRC_W-1:0] last_grant, win, cand;
  logic found;
  logic [NUM_SRC-1:0] push, pop;
  logic [ENT_W-1:0] head;
  logic [16:0] drop_sum;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(BUF_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction
  // Ready comes only from the registered count, so a full FIFO never accepts even when popping
  always_comb begin
    src_ready = '0;
    push = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = count[i] < CNT_W'(BUF_DEPTH);
      push[i] = src_valid[i] & src_ready[i] & ~flush;
      drop_sum = drop_sum + 17'(src_valid[i] & ~src_ready[i]);
    end
  end
  // Round-robin pick: first non-empty FIFO after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    cand = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!found && count[cand] != '0) begin
        found = 1'b1;
        win = cand;
      end
    end
    pop = found ? NUM_SRC'(1) << win : '0;
    head = found ? mem[win][rd_ptr[win]] : '0;
  end
  // FIFO storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
  end
  // FIFO control, grant pointer and registered broadcast; flush mirrors reset except drop_cnt
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i] <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      last_grant <= SRC_W'(NUM_SRC - 1);
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_src <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        if (push[i]) wr_ptr[i] <= nxt(wr_ptr[i]);
        if (pop[i]) rd_ptr[i] <= nxt(rd_ptr[i]);
      end
      if (found) last_grant <= win;
      cdb_valid <= found;
      cdb_tag <= head[ENT_W-1 -: TAG_W];
      cdb_data <= head[DATA_W-1:0];
      cdb_src <= win;
    end
  end
  // Saturating count of producers that asserted valid into a full FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table for the 2-source arbiter plus hand sequences on a 4-source instance
module tb_cdb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush;
  logic [1:0] src_valid, src_ready;
  logic [9:0] src_tag;
  logic [63:0] src_data;
  logic cdb_valid, cdb_src;
  logic [4:0] cdb_tag;
  logic [31:0] cdb_data;
  logic [15:0] drop_cnt;
  logic rst4_n, flush4, cv4;
  logic [3:0] v4, r4;
  logic [19:0] tag4;
  logic [127:0] data4;
  logic [4:0] ct4;
  logic [31:0] cd4;
  logic [1:0] cs4;
  logic [15:0] dc4;
  cdb_arbiter #(.NUM_SRC(2), .TAG_W(5), .DATA_W(32), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .drop_cnt(drop_cnt));
  cdb_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32), .BUF_DEPTH(1)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .flush(flush4), .src_valid(v4), .src_ready(r4),
    .src_tag(tag4), .src_data(data4), .cdb_valid(cv4), .cdb_tag(ct4),
    .cdb_data(cd4), .cdb_src(cs4), .drop_cnt(dc4));
  typedef struct {
    logic rst_n, flush;
    logic [1:0] v;
    logic [4:0] t0, t1;
    logic [31:0] d0, d1;
    logic ev;
    logic [4:0] et;
    logic [31:0] ed;
    logic es;
    logic [1:0] er;
    logic [15:0] edrop;
  } vec_t;
  vec_t tv[$];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask
  task automatic add(input int rs, input int fl, input int v, input int t0, input int d0,
                     input int t1, input int d1, input int ev, input int et, input int ed,
                     input int es, input int er, input int edrop);
    vec_t x;
    x.rst_n = 1'(rs); x.flush = 1'(fl); x.v = 2'(v);
    x.t0 = 5'(t0); x.d0 = 32'(d0); x.t1 = 5'(t1); x.d1 = 32'(d1);
    x.ev = 1'(ev); x.et = 5'(et); x.ed = 32'(ed); x.es = 1'(es);
    x.er = 2'(er); x.edrop = 16'(edrop);
    tv.push_back(x);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk4(input int row, input int ev, input int es, input int et, input int ed);
    chk("cv4", row, 32'(cv4), 32'(ev));
    chk("cs4", row, 32'(cs4), 32'(es));
    chk("ct4", row, 32'(ct4), 32'(et));
    chk("cd4", row, 32'(cd4), 32'(ed));
  endtask
  initial begin
    int ord[4];
    ord = '{2, 3, 0, 1};
    rst_n = 1'b0; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
    rst4_n = 1'b0; flush4 = 1'b0; v4 = '0; tag4 = '0; data4 = '0;
    // reset, then one push from each source
    add(0,0,0, 0,0, 0,0,      0,0,0,0, 3,0);
    add(1,0,3, 3,'hA, 7,'hB,  0,0,0,0, 3,0);
    add(1,0,0, 0,0, 0,0,      1,3,'hA,0, 3,0);
    add(1,0,0, 0,0, 0,0,      1,7,'hB,1, 3,0);
    add(1,0,0, 0,0, 0,0,      0,0,0,0, 3,0);
    // both sources push for 8 cycles, honouring ready
    add(1,0,3, 8,'h100, 16,'h200, 0,0,0,0, 3,0);
    add(1,0,3, 9,'h101, 17,'h201, 1,8,'h100,0, 1,0);
    add(1,0,1, 10,'h102, 0,0,     1,16,'h200,1, 2,0);
    add(1,0,2, 0,0, 18,'h202,     1,9,'h101,0, 1,0);
    add(1,0,1, 11,'h103, 0,0,     1,17,'h201,1, 2,0);
    add(1,0,2, 0,0, 19,'h203,     1,10,'h102,0, 1,0);
    add(1,0,1, 12,'h104, 0,0,     1,18,'h202,1, 2,0);
    add(1,0,2, 0,0, 20,'h204,     1,11,'h103,0, 1,0);
    add(1,0,0, 0,0, 0,0,          1,19,'h203,1, 3,0);
    add(1,0,0, 0,0, 0,0,          1,12,'h104,0, 3,0);
    add(1,0,0, 0,0, 0,0,          1,20,'h204,1, 3,0);
    add(1,0,0, 0,0, 0,0,          0,0,0,0, 3,0);
    // src0 back-to-back while src1 idle
    add(1,0,1, 1,'h11, 0,0,       0,0,0,0, 3,0);
    add(1,0,1, 2,'h12, 0,0,       1,1,'h11,0, 3,0);
    add(1,0,1, 4,'h13, 0,0,       1,2,'h12,0, 3,0);
    add(1,0,0, 0,0, 0,0,          1,4,'h13,0, 3,0);
    add(1,0,0, 0,0, 0,0,          0,0,0,0, 3,0);
    // protocol violations on src0 while full; 'hDEAD must never appear
    add(1,0,3, 21,'h300, 25,'h400, 0,0,0,0, 3,0);
    add(1,0,3, 22,'h301, 26,'h401, 1,25,'h400,1, 2,0);
    add(1,0,3, 30,'hDEAD, 27,'h402, 1,21,'h300,0, 1,1);
    add(1,0,1, 23,'h302, 0,0,      1,26,'h401,1, 2,1);
    add(1,0,3, 30,'hDEAD, 28,'h403, 1,22,'h301,0, 1,2);
    add(1,0,1, 24,'h303, 0,0,      1,27,'h402,1, 2,2);
    add(1,0,1, 30,'hDEAD, 0,0,     1,23,'h302,0, 3,3);
    add(1,0,0, 0,0, 0,0,           1,28,'h403,1, 3,3);
    add(1,0,0, 0,0, 0,0,           1,24,'h303,0, 3,3);
    add(1,0,0, 0,0, 0,0,           0,0,0,0, 3,3);
    // flush with buffered entries and a concurrent src1 push
    add(1,0,3, 1,'h500, 2,'h600,   0,0,0,0, 3,3);
    add(1,0,3, 3,'h501, 4,'h601,   1,2,'h600,1, 2,3);
    add(1,1,2, 0,0, 5,'h602,       0,0,0,0, 3,3);
    add(1,0,0, 0,0, 0,0,           0,0,0,0, 3,3);
    add(1,0,2, 0,0, 6,'h603,       0,0,0,0, 3,3);
    add(1,0,0, 0,0, 0,0,           1,6,'h603,1, 3,3);
    add(1,0,0, 0,0, 0,0,           0,0,0,0, 3,3);
    // flush after a src0 grant restores src0 priority
    add(1,0,1, 7,'h700, 0,0,       0,0,0,0, 3,3);
    add(1,0,0, 0,0, 0,0,           1,7,'h700,0, 3,3);
    add(1,1,0, 0,0, 0,0,           0,0,0,0, 3,3);
    add(1,0,3, 8,'h701, 9,'h702,   0,0,0,0, 3,3);
    add(1,0,0, 0,0, 0,0,           1,8,'h701,0, 3,3);
    add(1,0,0, 0,0, 0,0,           1,9,'h702,1, 3,3);
    // reset mid-stream beats flush and clears everything
    add(1,0,3, 10,'h710, 11,'h711, 0,0,0,0, 3,3);
    add(0,1,0, 0,0, 0,0,           0,0,0,0, 3,0);
    add(1,0,0, 0,0, 0,0,           0,0,0,0, 3,0);
    foreach (tv[n]) begin
      rst_n = tv[n].rst_n;
      flush = tv[n].flush;
      src_valid = tv[n].v;
      src_tag = {tv[n].t1, tv[n].t0};
      src_data = {tv[n].d1, tv[n].d0};
      tick();
      chk("cdb_valid", n, 32'(cdb_valid), 32'(tv[n].ev));
      chk("cdb_tag", n, 32'(cdb_tag), 32'(tv[n].et));
      chk("cdb_data", n, cdb_data, tv[n].ed);
      chk("cdb_src", n, 32'(cdb_src), 32'(tv[n].es));
      chk("src_ready", n, 32'(src_ready), 32'(tv[n].er));
      chk("drop_cnt", n, 32'(drop_cnt), 32'(tv[n].edrop));
    end
    rst_n = 1'b1; flush = 1'b0; src_valid = '0;
    // 4-source instance, depth 1
    tick();
    chk("r4_reset", 100, 32'(r4), 32'hF);
    chk4(100, 0, 0, 0, 0);
    chk("dc4_reset", 100, 32'(dc4), 0);
    rst4_n = 1'b1;
    v4 = 4'hF;
    tag4 = {5'd4, 5'd3, 5'd2, 5'd1};
    data4 = {32'h44, 32'h43, 32'h42, 32'h41};
    tick();
    chk("r4_full", 101, 32'(r4), 0);
    chk4(101, 0, 0, 0, 0);
    v4 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk4(102 + k, 1, k, k + 1, 'h41 + k);
    end
    v4 = 4'b0011;
    tag4 = {5'd0, 5'd0, 5'd6, 5'd5};
    data4 = {32'h0, 32'h0, 32'h52, 32'h51};
    tick();
    chk4(106, 0, 0, 0, 0);
    v4 = '0;
    tick();
    chk4(107, 1, 0, 5, 'h51);
    tick();
    chk4(108, 1, 1, 6, 'h52);
    v4 = 4'hF;
    tag4 = {5'd10, 5'd9, 5'd8, 5'd7};
    data4 = {32'h64, 32'h63, 32'h62, 32'h61};
    tick();
    chk4(109, 0, 0, 0, 0);
    v4 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk4(110 + k, 1, ord[k], 7 + ord[k], 'h61 + ord[k]);
    end
    tick();
    chk4(114, 0, 0, 0, 0);
    chk("dc4_clean", 114, 32'(dc4), 0);
    // drop saturation: everyone keeps pushing into full depth-1 FIFOs
    v4 = 4'hF;
    tick();
    chk("dc4_fill", 115, 32'(dc4), 0);
    tick();
    chk("dc4_four", 116, 32'(dc4), 4);
    tick();
    chk("dc4_seven", 117, 32'(dc4), 7);
    repeat (25000) @(posedge clk);
    #1;
    chk("dc4_sat", 118, 32'(dc4), 32'hFFFF);
    v4 = '0;
    tick();
    chk("dc4_hold", 119, 32'(dc4), 32'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
